debounce_multi: RTL and testbench

- Parametrised multi-channel successor of the single-purpose button debouncer.
- Debounces N_CH push-button inputs on the slow debounce clock (100 Hz).
- Per channel it provides a stable level, press and release pulses, a long-press pulse, and optional auto-repeat pulses.
- Feeds the traffic-light controller and later panels that need hold/repeat key semantics.

---
 rtl/debounce_pkg.sv | 8 +
 rtl/debounce_multi_if.sv | 11 +
 rtl/debounce_ch.sv | 56 +++++
 rtl/debounce_multi.sv | 32 +++
 tb/tb_debounce_multi.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared tick defaults and counter-width helper for the button debouncers
package debounce_pkg;
  localparam int LONG_TICKS_1S = 100;
  localparam int REPEAT_TICKS_200MS = 20;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: raw key inputs and debounced key events for N_CH channels
interface debounce_multi_if #(parameter int N_CH = 4);
  logic [N_CH-1:0] key_in;
  logic [N_CH-1:0] key_level;
  logic [N_CH-1:0] key_press;
  logic [N_CH-1:0] key_release;
  logic [N_CH-1:0] key_long;
  logic [N_CH-1:0] key_repeat;
  modport master(output key_in, input key_level, key_press, key_release, key_long, key_repeat);
  modport slave(input key_in, output key_level, key_press, key_release, key_long, key_repeat);
endinterface

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel with level, edge, long-press and auto-repeat detection
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LONG_TICKS = LONG_TICKS_1S,
  parameter int REPEAT_TICKS = REPEAT_TICKS_200MS,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk_db,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);
  localparam int HW = cnt_w(LONG_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);
  localparam logic [HW-1:0] L_MAX = HW'(LONG_TICKS);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_TICKS);
  logic [DEPTH-1:0] sr;
  logic prev;
  logic [HW-1:0] hold;
  logic [RW-1:0] rep, rep_nxt;
  logic rep_on;
  // repeat counter runs 1..R_MAX once the hold counter has saturated
  always_comb begin
    rep_on = REPEAT_EN && key_level && hold == L_MAX;
    rep_nxt = (rep == R_MAX) ? RW'(1) : rep + 1'b1;
  end
  always_ff @(posedge clk_db) begin
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
      hold <= '0;
      rep <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      sr <= {sr[DEPTH-2:0], key_in};
      key_level <= &sr ? 1'b1 : |sr ? key_level : 1'b0;
      prev <= key_level;
      key_press <= key_level & ~prev;
      key_release <= ~key_level & prev;
      hold <= !key_level ? '0 : hold == L_MAX ? hold : hold + 1'b1;
      key_long <= key_level && hold == L_MAX - 1'b1;
      rep <= rep_on ? rep_nxt : '0;
      key_repeat <= rep_on && rep_nxt == R_MAX;
    end
  end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent push-button debouncers on the slow debounce clock
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DEPTH = 3,
  parameter int LONG_TICKS = LONG_TICKS_1S,
  parameter int REPEAT_TICKS = REPEAT_TICKS_200MS,
  parameter logic [N_CH-1:0] REPEAT_EN = '1
) (
  input logic clk_db,
  input logic rst_n,
  debounce_multi_if.slave bus
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEPTH(DEPTH),
      .LONG_TICKS(LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN(REPEAT_EN[i])
    ) u_ch (
      .clk_db(clk_db),
      .rst_n(rst_n),
      .key_in(bus.key_in[i]),
      .key_level(bus.key_level[i]),
      .key_press(bus.key_press[i]),
      .key_release(bus.key_release[i]),
      .key_long(bus.key_long[i]),
      .key_repeat(bus.key_repeat[i])
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed and random stimulus checked against a run-length/elapsed-time model
module tb_debounce_multi;
  localparam int DEPTH = 3;
  localparam int LONG = 10;
  localparam int REP = 4;
  localparam logic [3:0] REP_EN = 4'b0111;
  logic clk_db = 1'b0;
  logic rst_n;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  debounce_multi_if #(.N_CH(4)) bus();
  debounce_multi #(
    .N_CH(4), .DEPTH(DEPTH), .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .REPEAT_EN(REP_EN)
  ) dut (
    .clk_db(clk_db),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk_db = ~clk_db;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // model: level follows runs of DEPTH identical samples; events derive from time since the rise
  int hi[4], lo[4], rise[4];
  bit lv[4], pv[4];
  bit nl;
  int held;
  logic [3:0] e_lvl, e_pr, e_rl, e_lg, e_rp;
  always @(posedge clk_db) begin
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        hi[c] = 0; lo[c] = DEPTH; lv[c] = 0; pv[c] = 0;
      end
      {e_lvl, e_pr, e_rl, e_lg, e_rp} = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        nl = hi[c] >= DEPTH ? 1'b1 : lo[c] >= DEPTH ? 1'b0 : lv[c];
        e_pr[c] = lv[c] && !pv[c];
        e_rl[c] = !lv[c] && pv[c];
        held = cyc - rise[c];
        e_lg[c] = lv[c] && held == LONG;
        e_rp[c] = lv[c] && REP_EN[c] && held > LONG && (held - LONG) % REP == 0;
        if (nl && !lv[c]) rise[c] = cyc;
        hi[c] = bus.key_in[c] ? hi[c] + 1 : 0;
        lo[c] = bus.key_in[c] ? 0 : lo[c] + 1;
        pv[c] = lv[c];
        lv[c] = nl;
        e_lvl[c] = nl;
      end
    end
    #1;
    chk("level", int'(bus.key_level), int'(e_lvl));
    chk("press", int'(bus.key_press), int'(e_pr));
    chk("release", int'(bus.key_release), int'(e_rl));
    chk("long", int'(bus.key_long), int'(e_lg));
    chk("repeat", int'(bus.key_repeat), int'(e_rp));
  end

  int n_lv[4], n_pr[4], n_rl[4], n_lg[4], n_rp[4];
  task automatic clr();
    for (int c = 0; c < 4; c++) begin
      n_lv[c] = 0; n_pr[c] = 0; n_rl[c] = 0; n_lg[c] = 0; n_rp[c] = 0;
    end
  endtask
  task automatic tick(input logic r, input logic [3:0] k);
    rst_n = r;
    bus.key_in = k;
    @(posedge clk_db);
    #2;
    for (int c = 0; c < 4; c++) begin
      n_lv[c] += int'(bus.key_level[c]);
      n_pr[c] += int'(bus.key_press[c]);
      n_rl[c] += int'(bus.key_release[c]);
      n_lg[c] += int'(bus.key_long[c]);
      n_rp[c] += int'(bus.key_repeat[c]);
    end
  endtask
  function automatic int outs();
    return int'({bus.key_level, bus.key_press, bus.key_release, bus.key_long, bus.key_repeat});
  endfunction

  logic [3:0] k;
  initial begin
    rst_n = 1'b0;
    bus.key_in = 4'hF;
    clr();
    tick(0, 4'hF);
    tick(0, 4'hF);
    chk("rst_outs", outs(), 0);
    for (int i = 1; i <= 6; i++) begin
      tick(1, 4'hF);
      if (i == 3) chk("rst_lvl3", int'(bus.key_level), 0);
      if (i == 4) chk("rst_lvl4", int'(bus.key_level), 4'hF);
      if (i == 4) chk("rst_pr4", int'(bus.key_press), 0);
      if (i == 5) chk("rst_pr5", int'(bus.key_press), 4'hF);
      if (i == 6) chk("rst_pr6", int'(bus.key_press), 0);
    end
    repeat (8) tick(1, 4'h0);
    clr();
    repeat (2) tick(1, 4'h1);
    repeat (8) tick(1, 4'h0);
    chk("glitch_lvl", n_lv[0], 0);
    chk("glitch_pr", n_pr[0], 0);
    clr();
    repeat (6) tick(1, 4'h2);
    repeat (8) tick(1, 4'h0);
    chk("short_pr", n_pr[1], 1);
    chk("short_rl", n_rl[1], 1);
    chk("short_lg", n_lg[1], 0);
    clr();
    for (int i = 1; i <= 30; i++) begin
      tick(1, 4'hC);
      if (i == 14) chk("long_t", int'(bus.key_long), 4'hC);
      if (i == 18) chk("rep_t", int'(bus.key_repeat), 4'h4);
    end
    repeat (8) tick(1, 4'h0);
    chk("hold_lg2", n_lg[2], 1);
    chk("hold_rp2", n_rp[2], 5);
    chk("hold_pr2", n_pr[2], 1);
    chk("hold_rl2", n_rl[2], 1);
    chk("hold_lg3", n_lg[3], 1);
    chk("hold_rp3", n_rp[3], 0);
    clr();
    repeat (15) tick(1, 4'h4);
    tick(0, 4'h4);
    chk("midrst_outs", outs(), 0);
    clr();
    for (int i = 1; i <= 16; i++) begin
      tick(1, 4'h4);
      if (i == 4) chk("midrst_pr4", int'(bus.key_press), 0);
      if (i == 5) chk("midrst_pr5", int'(bus.key_press), 4'h4);
      if (i == 14) chk("midrst_lg", int'(bus.key_long), 4'h4);
    end
    chk("midrst_rl", n_rl[2], 0);
    chk("midrst_lgn", n_lg[2], 1);
    repeat (8) tick(1, 4'h0);
    k = 4'h0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, (i / 100) % 2 ? 2 : 25) == 0) k[c] = ~k[c];
      tick($urandom_range(0, 249) != 0, k);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
